// File: rtl/nn_decode_execute_stage.sv
// ----------------------------------------------------------------------------
// nn_decode_execute_stage
// Decode/execute slice of the NN CPU pipeline. The 4-bit opcode is decoded
// into control signals, and those controls are latched together with the
// operands in the ID/EX register. Execution runs through two chained ALUs:
// ALU2 combines ALU1's result with a third operand, which gives a single-cycle
// multiply-accumulate (A*B + C) for neuron evaluation.
// ----------------------------------------------------------------------------
module nn_decode_execute_stage #(
    parameter int BUS_WIDTH      = 32,
    parameter int REGISTER       = 6,
    parameter int OPCODE         = 4,
    parameter int ALU_FUNCT_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [OPCODE-1:0]     OpD,
    input  logic [BUS_WIDTH-1:0]  Src1AD,
    input  logic [BUS_WIDTH-1:0]  Src1BD,
    input  logic [BUS_WIDTH-1:0]  Src1CD,
    input  logic [REGISTER-1:0]   RtD,
    input  logic [REGISTER-1:0]   RdD,
    input  logic [BUS_WIDTH-1:0]  SignImmD,
    output logic                  PCEn,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic                  MemtoReg,
    output logic [REGISTER-1:0]   WriteDstReg,
    output logic [BUS_WIDTH-1:0]  ALUOut1,
    output logic [BUS_WIDTH-1:0]  ALUOut2,
    output logic [BUS_WIDTH-1:0]  WriteData
);

    // ------------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------------
    localparam logic [OPCODE-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPCODE-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPCODE-1:0] OP_SUB  = 4'b0010;
    localparam logic [OPCODE-1:0] OP_MUL  = 4'b0011;
    localparam logic [OPCODE-1:0] OP_MAC  = 4'b0100;
    localparam logic [OPCODE-1:0] OP_AND  = 4'b0101;
    localparam logic [OPCODE-1:0] OP_OR   = 4'b0110;
    localparam logic [OPCODE-1:0] OP_ADDI = 4'b0111;
    localparam logic [OPCODE-1:0] OP_LW   = 4'b1000;
    localparam logic [OPCODE-1:0] OP_SW   = 4'b1001;
    localparam logic [OPCODE-1:0] OP_RELU = 4'b1010;
    localparam logic [OPCODE-1:0] OP_SLT  = 4'b1011;
    localparam logic [OPCODE-1:0] OP_HALT = 4'b1111;

    // ------------------------------------------------------------------------
    // ALU function codes
    // ------------------------------------------------------------------------
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_AND   = 3'b010;
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_OR    = 3'b011;
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_MUL   = 3'b100;
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_SLT   = 3'b101;
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_PASSA = 3'b110;
    localparam logic [ALU_FUNCT_BITS-1:0] ALU_RELU  = 3'b111;

    localparam logic [BUS_WIDTH-1:0] ZERO_W = {BUS_WIDTH{1'b0}};
    localparam logic [BUS_WIDTH-1:0] ONE_W  = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Shared ALU: result is truncated to BUS_WIDTH; carry/overflow dropped.
    // MUL evaluates in a BUS_WIDTH context, so only the low product bits are
    // formed. SLT and RELU treat operands as two's complement.
    // ------------------------------------------------------------------------
    function automatic logic [BUS_WIDTH-1:0] alu_calc(
        input logic [ALU_FUNCT_BITS-1:0] funct,
        input logic [BUS_WIDTH-1:0]      a,
        input logic [BUS_WIDTH-1:0]      b
    );
        logic [BUS_WIDTH-1:0] res;
        case (funct)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_MUL:   res = a * b;
            ALU_SLT:   res = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
            ALU_PASSA: res = a;
            ALU_RELU:  res = a[BUS_WIDTH-1] ? ZERO_W : a;
            default:   res = ZERO_W;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Decode-stage control signals
    // ------------------------------------------------------------------------
    logic                      pcen_s;
    logic                      regwrite_s;
    logic                      memwrite_s;
    logic                      memread_s;
    logic                      memtoreg_s;
    logic                      regdst_s;
    logic                      alusrc_s;
    logic [ALU_FUNCT_BITS-1:0] alu1_ctrl_s;
    logic [ALU_FUNCT_BITS-1:0] alu2_ctrl_s;

    // ------------------------------------------------------------------------
    // ID/EX pipeline register contents
    // ------------------------------------------------------------------------
    logic                      pcen_r;
    logic                      regwrite_r;
    logic                      memwrite_r;
    logic                      memread_r;
    logic                      memtoreg_r;
    logic                      regdst_r;
    logic                      alusrc_r;
    logic [ALU_FUNCT_BITS-1:0] alu1_ctrl_r;
    logic [ALU_FUNCT_BITS-1:0] alu2_ctrl_r;
    logic [BUS_WIDTH-1:0]      src1a_r;
    logic [BUS_WIDTH-1:0]      src1b_r;
    logic [BUS_WIDTH-1:0]      src1c_r;
    logic [REGISTER-1:0]       rt_r;
    logic [REGISTER-1:0]       rd_r;
    logic [BUS_WIDTH-1:0]      signimm_r;

    // ------------------------------------------------------------------------
    // Execute-stage combinational signals
    // ------------------------------------------------------------------------
    logic [BUS_WIDTH-1:0]      alu1_srcb_s;
    logic [BUS_WIDTH-1:0]      alu1_out_s;
    logic [BUS_WIDTH-1:0]      alu2_out_s;
    logic [REGISTER-1:0]       wdst_s;

    // Decode the opcode; reserved codes fall through to NOP behaviour.
    always_comb begin
        pcen_s      = 1'b1;
        regwrite_s  = 1'b0;
        memwrite_s  = 1'b0;
        memread_s   = 1'b0;
        memtoreg_s  = 1'b0;
        regdst_s    = 1'b0;
        alusrc_s    = 1'b0;
        alu1_ctrl_s = ALU_ADD;
        alu2_ctrl_s = ALU_PASSA;
        case (OpD)
            OP_NOP: begin
                alu1_ctrl_s = ALU_ADD;
            end
            OP_ADD: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_ADD;
            end
            OP_SUB: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_SUB;
            end
            OP_MUL: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_MUL;
            end
            OP_MAC: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_MUL;
                alu2_ctrl_s = ALU_ADD;
            end
            OP_AND: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_AND;
            end
            OP_OR: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_OR;
            end
            OP_ADDI: begin
                regwrite_s  = 1'b1;
                alusrc_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_ADD;
            end
            OP_LW: begin
                regwrite_s  = 1'b1;
                alusrc_s    = 1'b1;
                memread_s   = 1'b1;
                alu1_ctrl_s = ALU_ADD;
            end
            OP_SW: begin
                memwrite_s  = 1'b1;
                alusrc_s    = 1'b1;
                alu1_ctrl_s = ALU_ADD;
            end
            OP_RELU: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_RELU;
            end
            OP_SLT: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                memtoreg_s  = 1'b1;
                alu1_ctrl_s = ALU_SLT;
            end
            OP_HALT: begin
                // Everything zero, including the ALU2 select (ADD), so a
                // halted stage looks exactly like the reset state.
                pcen_s      = 1'b0;
                alu1_ctrl_s = ALU_ADD;
                alu2_ctrl_s = ALU_ADD;
            end
            default: begin
                pcen_s      = 1'b1;
                alu1_ctrl_s = ALU_ADD;
                alu2_ctrl_s = ALU_PASSA;
            end
        endcase
    end

    // ID/EX register: loads every cycle; reset clears it to an all-zero
    // (halted NOP) state so no in-flight write enable survives.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcen_r      <= 1'b0;
            regwrite_r  <= 1'b0;
            memwrite_r  <= 1'b0;
            memread_r   <= 1'b0;
            memtoreg_r  <= 1'b0;
            regdst_r    <= 1'b0;
            alusrc_r    <= 1'b0;
            alu1_ctrl_r <= {ALU_FUNCT_BITS{1'b0}};
            alu2_ctrl_r <= {ALU_FUNCT_BITS{1'b0}};
            src1a_r     <= {BUS_WIDTH{1'b0}};
            src1b_r     <= {BUS_WIDTH{1'b0}};
            src1c_r     <= {BUS_WIDTH{1'b0}};
            rt_r        <= {REGISTER{1'b0}};
            rd_r        <= {REGISTER{1'b0}};
            signimm_r   <= {BUS_WIDTH{1'b0}};
        end else begin
            pcen_r      <= pcen_s;
            regwrite_r  <= regwrite_s;
            memwrite_r  <= memwrite_s;
            memread_r   <= memread_s;
            memtoreg_r  <= memtoreg_s;
            regdst_r    <= regdst_s;
            alusrc_r    <= alusrc_s;
            alu1_ctrl_r <= alu1_ctrl_s;
            alu2_ctrl_r <= alu2_ctrl_s;
            src1a_r     <= Src1AD;
            src1b_r     <= Src1BD;
            src1c_r     <= Src1CD;
            rt_r        <= RtD;
            rd_r        <= RdD;
            signimm_r   <= SignImmD;
        end
    end

    // ALU1 operand B select: immediate for ADDI/LW/SW, register otherwise.
    always_comb begin
        if (alusrc_r) begin
            alu1_srcb_s = signimm_r;
        end else begin
            alu1_srcb_s = src1b_r;
        end
    end

    // Chained ALUs: ALU2 post-processes ALU1's result with operand C.
    always_comb begin
        alu1_out_s = alu_calc(alu1_ctrl_r, src1a_r, alu1_srcb_s);
        alu2_out_s = alu_calc(alu2_ctrl_r, alu1_out_s, src1c_r);
    end

    // Destination register select: Rd for register-format ops, Rt otherwise.
    always_comb begin
        if (regdst_r) begin
            wdst_s = rd_r;
        end else begin
            wdst_s = rt_r;
        end
    end

    assign PCEn        = pcen_r;
    assign RegWrite    = regwrite_r;
    assign MemWrite    = memwrite_r;
    assign MemRead     = memread_r;
    assign MemtoReg    = memtoreg_r;
    assign WriteDstReg = wdst_s;
    assign ALUOut1     = alu1_out_s;
    assign ALUOut2     = alu2_out_s;
    assign WriteData   = src1b_r;

endmodule

// File: tb/tb_nn_decode_execute_stage.sv
// ----------------------------------------------------------------------------
// Testbench for nn_decode_execute_stage: table of directed vectors with
// hand-computed expectations plus hand-written reset sequences.
// ----------------------------------------------------------------------------
module tb_nn_decode_execute_stage;

    logic        CLK;
    logic        RST;
    logic [3:0]  OpD;
    logic [31:0] Src1AD;
    logic [31:0] Src1BD;
    logic [31:0] Src1CD;
    logic [5:0]  RtD;
    logic [5:0]  RdD;
    logic [31:0] SignImmD;
    logic        PCEn;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic        MemtoReg;
    logic [5:0]  WriteDstReg;
    logic [31:0] ALUOut1;
    logic [31:0] ALUOut2;
    logic [31:0] WriteData;

    int errors;
    int checks;

    nn_decode_execute_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .OpD         (OpD),
        .Src1AD      (Src1AD),
        .Src1BD      (Src1BD),
        .Src1CD      (Src1CD),
        .RtD         (RtD),
        .RdD         (RdD),
        .SignImmD    (SignImmD),
        .PCEn        (PCEn),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemtoReg    (MemtoReg),
        .WriteDstReg (WriteDstReg),
        .ALUOut1     (ALUOut1),
        .ALUOut2     (ALUOut2),
        .WriteData   (WriteData)
    );

    // Free-running clock, 10 time units per period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] imm;
        logic [5:0]  rt;
        logic [5:0]  rd;
        logic        pcen;
        logic        rw;
        logic        mw;
        logic        mr;
        logic        m2r;
        logic [5:0]  wdst;
        logic [31:0] alu1;
        logic [31:0] alu2;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] imm,
                         input logic [5:0] rt, input logic [5:0] rd);
        OpD = op; Src1AD = a; Src1BD = b; Src1CD = c; SignImmD = imm; RtD = rt; RdD = rd;
    endtask

    task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] imm,
                       input logic [5:0] rt, input logic [5:0] rd,
                       input logic pcen, input logic rw, input logic mw, input logic mr,
                       input logic m2r, input logic [5:0] wdst,
                       input logic [31:0] alu1, input logic [31:0] alu2, input logic [31:0] wdata);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.imm = imm; v.rt = rt; v.rd = rd;
        v.pcen = pcen; v.rw = rw; v.mw = mw; v.mr = mr; v.m2r = m2r; v.wdst = wdst;
        v.alu1 = alu1; v.alu2 = alu2; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    // Compare every output against the expectation of one record.
    task automatic check_all(input string tag, input vec_t v);
        chk({tag, "_pcen"},  {31'd0, PCEn},      {31'd0, v.pcen});
        chk({tag, "_rw"},    {31'd0, RegWrite},  {31'd0, v.rw});
        chk({tag, "_mw"},    {31'd0, MemWrite},  {31'd0, v.mw});
        chk({tag, "_mr"},    {31'd0, MemRead},   {31'd0, v.mr});
        chk({tag, "_m2r"},   {31'd0, MemtoReg},  {31'd0, v.m2r});
        chk({tag, "_wdst"},  {26'd0, WriteDstReg}, {26'd0, v.wdst});
        chk({tag, "_alu1"},  ALUOut1,  v.alu1);
        chk({tag, "_alu2"},  ALUOut2,  v.alu2);
        chk({tag, "_wdata"}, WriteData, v.wdata);
    endtask

    vec_t zero_v;
    vec_t mac_v;

    initial begin
        errors = 0;
        checks = 0;
        RST = 1'b1;
        drive(4'b0100, 32'd3, 32'd5, 32'd7, 32'd0, 6'd4, 6'd9);

        // Reset-state expectation: everything zero.
        zero_v = '{4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 6'd0, 6'd0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0};
        mac_v  = '{4'd4, 32'd3, 32'd5, 32'd7, 32'd0, 6'd4, 6'd9,
                   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd9, 32'd15, 32'd22, 32'd5};

        //   op     A             B             C         Imm           Rt     Rd     pc rw mw mr m2r wdst  ALU1          ALU2          WData
        add(4'h4, 32'd3,        32'd5,        32'd7,    32'd0,        6'd4,  6'd9,  1, 1, 0, 0, 1, 6'd9,  32'd15,       32'd22,       32'd5);
        add(4'h7, 32'd10,       32'h11,       32'h22,   32'hFFFFFFFE, 6'd2,  6'd3,  1, 1, 0, 0, 1, 6'd2,  32'd8,        32'd8,        32'h11);
        add(4'h2, 32'd3,        32'd5,        32'd0,    32'd0,        6'd1,  6'd6,  1, 1, 0, 0, 1, 6'd6,  32'hFFFFFFFE, 32'hFFFFFFFE, 32'd5);
        add(4'h8, 32'd100,      32'd7,        32'd9,    32'd4,        6'd5,  6'd8,  1, 1, 0, 1, 0, 6'd5,  32'd104,      32'd104,      32'd7);
        add(4'h9, 32'd200,      32'hDEAD,     32'd9,    32'd8,        6'd10, 6'd11, 1, 0, 1, 0, 0, 6'd10, 32'd208,      32'd208,      32'hDEAD);
        add(4'hA, 32'h80000001, 32'd3,        32'd9,    32'd0,        6'd1,  6'd12, 1, 1, 0, 0, 1, 6'd12, 32'd0,        32'd0,        32'd3);
        add(4'hA, 32'd5,        32'd3,        32'd9,    32'd0,        6'd1,  6'd13, 1, 1, 0, 0, 1, 6'd13, 32'd5,        32'd5,        32'd3);
        add(4'hB, 32'hFFFFFFFF, 32'd1,        32'd9,    32'd0,        6'd1,  6'd14, 1, 1, 0, 0, 1, 6'd14, 32'd1,        32'd1,        32'd1);
        add(4'hB, 32'd1,        32'hFFFFFFFF, 32'd9,    32'd0,        6'd1,  6'd15, 1, 1, 0, 0, 1, 6'd15, 32'd0,        32'd0,        32'hFFFFFFFF);
        add(4'h3, 32'h00010001, 32'h00010001, 32'd9,    32'd0,        6'd1,  6'd16, 1, 1, 0, 0, 1, 6'd16, 32'h00020001, 32'h00020001, 32'h00010001);
        add(4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 32'd9,    32'd0,        6'd1,  6'd17, 1, 1, 0, 0, 1, 6'd17, 32'hF000F000, 32'hF000F000, 32'hFF00FF00);
        add(4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 32'd9,    32'd0,        6'd1,  6'd18, 1, 1, 0, 0, 1, 6'd18, 32'hFFF0FFF0, 32'hFFF0FFF0, 32'hFF00FF00);
        add(4'h1, 32'hFFFFFFFF, 32'd2,        32'd9,    32'd0,        6'd1,  6'd19, 1, 1, 0, 0, 1, 6'd19, 32'd1,        32'd1,        32'd2);
        add(4'h0, 32'd1,        32'd2,        32'd3,    32'd50,       6'd20, 6'd21, 1, 0, 0, 0, 0, 6'd20, 32'd3,        32'd3,        32'd2);
        add(4'hF, 32'd0,        32'd0,        32'd0,    32'd0,        6'd22, 6'd23, 0, 0, 0, 0, 0, 6'd22, 32'd0,        32'd0,        32'd0);
        add(4'hD, 32'd1,        32'd2,        32'd3,    32'd0,        6'd24, 6'd25, 1, 0, 0, 0, 0, 6'd24, 32'd3,        32'd3,        32'd2);
        add(4'hC, 32'd4,        32'd4,        32'd1,    32'd0,        6'd26, 6'd27, 1, 0, 0, 0, 0, 6'd26, 32'd8,        32'd8,        32'd4);
        add(4'hE, 32'd6,        32'd1,        32'd1,    32'd0,        6'd28, 6'd29, 1, 0, 0, 0, 0, 6'd28, 32'd7,        32'd7,        32'd1);
        add(4'h4, 32'hFFFFFFFF, 32'd2,        32'd10,   32'd0,        6'd30, 6'd31, 1, 1, 0, 0, 1, 6'd31, 32'hFFFFFFFE, 32'd8,        32'd2);

        // Reset held with a MAC on the inputs: outputs stay zero across edges.
        #2;
        check_all("rst_hold0", zero_v);
        repeat (2) @(posedge CLK);
        #1;
        check_all("rst_hold2", zero_v);
        // Release between edges: still zero until the next rising edge.
        RST = 1'b0;
        #1;
        check_all("rst_release", zero_v);
        @(posedge CLK);
        #1;
        check_all("rst_first", mac_v);

        // Directed table.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].imm, vecs[i].rt, vecs[i].rd);
            @(posedge CLK);
            #1;
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Mid-operation reset: an in-flight store must lose its write enable
        // immediately, without waiting for a clock edge.
        drive(4'h9, 32'd200, 32'hDEAD, 32'd9, 32'd8, 6'd10, 6'd11);
        @(posedge CLK);
        #1;
        chk("pre_rst_mw", {31'd0, MemWrite}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check_all("rst_async", zero_v);
        @(negedge CLK);
        RST = 1'b0;
        drive(4'h4, 32'd3, 32'd5, 32'd7, 32'd0, 6'd4, 6'd9);
        @(posedge CLK);
        #1;
        check_all("rst_recover", mac_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nn_decode_execute_stage.md
Name: nn_decode_execute_stage

Overview:
- Decode/execute slice of the NN CPU pipeline.
- Decodes the 4-bit opcode into control signals and latches control plus operands in an ID/EX pipeline register.
- Executes through two chained ALUs: ALU2 combines ALU1's result with a third operand, which gives multiply-accumulate for neuron evaluation.
- Sits between register-file/sign-extend (decode) and data memory/write-back.

Parameters:
- BUS_WIDTH, 32, datapath width.
- REGISTER, 6, register address width.
- OPCODE, 4, opcode width.
- ALU_FUNCT_BITS, 3, ALU function select width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- OpD  in  4  opcode (instr[31:28]) of the decode-stage instruction.
- Src1AD  in  32  register operand A.
- Src1BD  in  32  register operand B.
- Src1CD  in  32  register operand C.
- RtD  in  6  instr[21:16].
- RdD  in  6  instr[15:10].
- SignImmD  in  32  sign-extended immediate.
- PCEn  out  1  registered PC-advance enable.
- RegWrite  out  1  registered register-file write enable.
- MemWrite  out  1  registered data-memory write enable.
- MemRead  out  1  registered data-memory read enable.
- MemtoReg  out  1  registered write-back select (1=ALUOut2, 0=memory data).
- WriteDstReg  out  6  destination register (Rd if RegDst=1, else Rt).
- ALUOut1  out  32  ALU1 result.
- ALUOut2  out  32  ALU2 result; also the memory address.
- WriteData  out  32  registered Src1B, used as store data.

Behaviour:
- ALU function codes (combinational, result width 32, overflow/carry discarded):
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 MUL, low 32 bits of the product
  - 101 SLT, signed: result is 1 if A<B, else 0
  - 110 PASSA
  - 111 RELU: 0 if A is negative (signed), else A
- Opcode decode (combinational). Signals not listed are 0; ALU2=PASSA unless stated. All opcodes set PCEn=1 except HALT.
  - 0000 NOP: ALU1=ADD.
  - 0001 ADD: RegWrite, RegDst, MemtoReg; ALU1=ADD.
  - 0010 SUB: as ADD, but ALU1=SUB.
  - 0011 MUL: as ADD, but ALU1=MUL.
  - 0100 MAC: as ADD, but ALU1=MUL, ALU2=ADD. Result = A*B + C.
  - 0101 AND: as ADD, but ALU1=AND.
  - 0110 OR: as ADD, but ALU1=OR.
  - 0111 ADDI: RegWrite, ALUSrc, MemtoReg; RegDst=0; ALU1=ADD.
  - 1000 LW: RegWrite, ALUSrc, MemRead; MemtoReg=0; RegDst=0; ALU1=ADD.
  - 1001 SW: MemWrite, ALUSrc; ALU1=ADD.
  - 1010 RELU: as ADD, but ALU1=RELU.
  - 1011 SLT: as ADD, but ALU1=SLT.
  - 1111 HALT: PCEn=0; all other signals 0.
  - 1100-1110 are reserved and decode as NOP (PCEn=1).
- ID/EX register:
  - On each rising CLK it captures the decoded controls (PCEn, RegWrite, MemWrite, MemRead, MemtoReg, RegDst, ALUSrc, ALU1/ALU2 control), Src1A/B/C, Rt, Rd and SignImm.
  - There is no enable; the register loads every cycle.
- Execute datapath, combinational from registered values:
  - ALU1.SrcA = Src1A.
  - ALU1.SrcB = SignImm if ALUSrc=1, else Src1B.
  - ALU2.SrcA = ALUOut1; ALU2.SrcB = Src1C.
  - WriteDstReg = RegDst ? Rd : Rt.
  - WriteData = Src1B.
- Latency: a decode-stage input presented before edge N appears on the registered outputs after edge N. ALU outputs are valid in that same cycle, after combinational delay.
- Reset:
  - RST=1 immediately clears every pipeline register, including PCEn, to 0. This is equivalent to a NOP with PCEn=0.
  - Outputs then read: ALUOut1=0, ALUOut2=0 (ADD/PASSA of zeros), WriteDstReg=0.
  - On release, the first rising edge loads the decode of the current inputs.
  - RST asserted mid-operation discards the in-flight instruction, so no write enable survives.
- Back-to-back instructions have no hazard handling; forwarding/stall is out of scope.

Test Plan:
- Reset: assert RST while OpD=0100 with nonzero operands -> all control outputs 0, ALUOut1=0, ALUOut2=0, WriteDstReg=0, held until the first edge after release.
- MAC: OpD=0100, A=3, B=5, C=7, Rd=9, Rt=4 -> after one edge ALUOut1=15, ALUOut2=22, WriteDstReg=9, RegWrite=1, MemtoReg=1, PCEn=1.
- ADDI/SUB: OpD=0111, A=10, Imm=0xFFFFFFFE, Rt=2 -> ALUOut2=8, WriteDstReg=2. Then OpD=0010, A=3, B=5 -> ALUOut2=0xFFFFFFFE.
- Load/store: OpD=1000, A=100, Imm=4 -> ALUOut2=104, MemRead=1, MemtoReg=0. Then OpD=1001, B=0xDEAD -> MemWrite=1, WriteData=0xDEAD, RegWrite=0.
- RELU/SLT: OpD=1010, A=0x80000001 -> ALUOut2=0. Then A=5 -> ALUOut2=5. Then OpD=1011, A=-1, B=1 -> ALUOut2=1.
- HALT/NOP/reserved: OpD=1111 -> PCEn=0 and all writes 0. Then OpD=1101 -> PCEn=1 and all writes 0.
